// File: rtl/enc_stream_hamming_if.sv
// Stream bundle for enc_stream_hamming: info-word side, codeword side and,
// when ENC_ERR_INJECT_EN is defined, the error-injection mask.
interface enc_stream_hamming_if #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MODE_W             = 2
);
  localparam int MAX_INFO_WIDTH = MAX_CODEWORD_WIDTH - $clog2(MAX_CODEWORD_WIDTH) - 1;

  logic                          in_valid;
  logic                          in_ready;
  logic [MAX_INFO_WIDTH-1:0]     data_in;
  logic [MODE_W-1:0]             work_mod;
  logic                          out_valid;
  logic                          out_ready;
  logic [MAX_CODEWORD_WIDTH-1:0] data_out;
  logic [MODE_W-1:0]             out_mod;
  logic                          out_err;

`ifdef ENC_ERR_INJECT_EN
  logic [MAX_CODEWORD_WIDTH-1:0] inj_mask;

  modport master (
    output in_valid, data_in, work_mod, out_ready, inj_mask,
    input  in_ready, out_valid, data_out, out_mod, out_err
  );
  modport slave (
    input  in_valid, data_in, work_mod, out_ready, inj_mask,
    output in_ready, out_valid, data_out, out_mod, out_err
  );
`else
  modport master (
    output in_valid, data_in, work_mod, out_ready,
    input  in_ready, out_valid, data_out, out_mod, out_err
  );
  modport slave (
    input  in_valid, data_in, work_mod, out_ready,
    output in_ready, out_valid, data_out, out_mod, out_err
  );
`endif
endinterface

// File: rtl/enc_stream_hamming.sv
// Streaming extended-Hamming (SECDED) encoder, two-stage elastic pipeline.
// Optional codeword error injection is enabled by defining ENC_ERR_INJECT_EN.
module enc_stream_hamming #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MODE_W             = 2
) (
  input logic                 clk,
  input logic                 rst,
  enc_stream_hamming_if.slave bus
);
  localparam int LOG_N   = $clog2(MAX_CODEWORD_WIDTH);
  localparam int N_MODES = LOG_N - 2;
  localparam int CW      = MAX_CODEWORD_WIDTH;
  localparam int IW      = MAX_CODEWORD_WIDTH - LOG_N - 1;

  localparam logic [31:0] N_MODES_U = N_MODES;
  localparam logic [31:0] IW_U      = IW;

  typedef logic [IW-1:0]    info_t;
  typedef logic [CW-1:0]    cw_t;
  typedef logic [LOG_N-1:0] par_t;

  localparam info_t INFO_ONES = '1;

  // Column j selects the info bits whose Hamming position has bit j set;
  // info bit i sits at the i-th non-power-of-two position (3,5,6,7,9,...).
  function automatic logic [LOG_N-1:0][IW-1:0] col_masks();
    logic [LOG_N-1:0][IW-1:0] m;
    int unsigned pos;
    m   = '0;
    pos = 3;
    for (int unsigned i = 0; i < IW; i++) begin
      if ((pos & (pos - 1)) == 0) pos++;
      for (int unsigned j = 0; j < LOG_N; j++) begin
        m[j][i] = ((pos >> j) & 1) == 1;
      end
      pos++;
    end
    return m;
  endfunction

  localparam logic [LOG_N-1:0][IW-1:0] COL_MASK = col_masks();

  logic              s1_valid_q;
  info_t             s1_info_q;
  par_t              s1_par_q;
  logic [MODE_W-1:0] s1_mode_q;
  logic              s1_err_q;

  logic              out_valid_q;
  cw_t               cw_q;
  logic [MODE_W-1:0] out_mod_q;
  logic              out_err_q;

  logic        s2_load;
  logic        s1_load;
  logic        push;
  logic        legal_in;
  logic [31:0] n_in;
  logic [31:0] r_in;
  logic [31:0] k_in;
  info_t       info_d;
  par_t        par_d;
  logic [31:0] r_s1;
  logic        overall;
  cw_t         cw_d;

  assign s2_load      = !out_valid_q || bus.out_ready;
  assign s1_load      = !s1_valid_q || s2_load;
  assign push         = bus.in_valid && s1_load;
  assign bus.in_ready = s1_load;

  always_comb begin
    legal_in = 32'(bus.work_mod) < N_MODES_U;
    n_in     = 32'd8 << bus.work_mod;
    r_in     = 32'd4 + 32'(bus.work_mod);
    k_in     = n_in - r_in;
    info_d   = legal_in ? (bus.data_in & (INFO_ONES >> (IW_U - k_in))) : '0;
    par_d    = '0;
    for (int unsigned j = 0; j < LOG_N; j++) begin
      par_d[j] = ^(info_d & COL_MASK[j]);
    end
  end

`ifdef ENC_ERR_INJECT_EN
  localparam cw_t         CW_ONES = '1;
  localparam logic [31:0] CW_U    = CW;
  logic [31:0] n_s1;
`endif

  // Low parity bits above r-2 are zero by construction, so OR-ing them in is safe.
  always_comb begin
    r_s1    = 32'd4 + 32'(s1_mode_q);
    overall = (^s1_info_q) ^ (^s1_par_q);
    cw_d    = (cw_t'(s1_info_q) << r_s1) | (cw_t'(overall) << (r_s1 - 32'd1)) | cw_t'(s1_par_q);
`ifdef ENC_ERR_INJECT_EN
    n_s1 = 32'd8 << s1_mode_q;
    if (!s1_err_q) cw_d = cw_d ^ (bus.inj_mask & (CW_ONES >> (CW_U - n_s1)));
`endif
    if (s1_err_q) cw_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_info_q   <= '0;
      s1_par_q    <= '0;
      s1_mode_q   <= '0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      cw_q        <= '0;
      out_mod_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      if (s1_load) s1_valid_q <= bus.in_valid;
      if (push) begin
        s1_info_q <= info_d;
        s1_par_q  <= par_d;
        s1_mode_q <= bus.work_mod;
        s1_err_q  <= !legal_in;
      end
      if (s2_load) out_valid_q <= s1_valid_q;
      if (s2_load && s1_valid_q) begin
        cw_q      <= cw_d;
        out_mod_q <= s1_mode_q;
        out_err_q <= s1_err_q;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = cw_q;
  assign bus.out_mod   = out_mod_q;
  assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_enc_stream_hamming.sv
// Bench for enc_stream_hamming: directed vectors plus randomized traffic scored
// against a position-based Hamming model; covers ENC_ERR_INJECT_EN when defined.
module tb_enc_stream_hamming;
  localparam int CW = 32;
  localparam int IW = 26;

  logic clk;
  logic rst;

  enc_stream_hamming_if #(.MAX_CODEWORD_WIDTH(CW), .MODE_W(2)) bus ();

  enc_stream_hamming #(.MAX_CODEWORD_WIDTH(CW), .MODE_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] cw;
    logic [1:0]    mode;
    logic          err;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Lay the word out on Hamming positions 1..n-1 and derive each parity bit from them.
  function automatic logic [CW-1:0] ref_cw(input logic [IW-1:0] info, input int unsigned mode,
                                           input logic [CW-1:0] inj);
    int unsigned n, r, k, idx;
    logic [5:0]    p;
    logic [CW-1:0] cw;
    logic [CW-1:0] nmask;
    logic          ov;
    if (mode >= 3) return '0;
    n   = 8 << mode;
    r   = mode + 4;
    k   = n - r;
    p   = '0;
    ov  = 1'b0;
    idx = 0;
    for (int unsigned pos = 1; pos < n; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (info[idx]) begin
          for (int unsigned j = 0; j < r - 1; j++) if (pos[j]) p[j] = ~p[j];
        end
        ov = ov ^ info[idx];
        idx++;
      end
    end
    for (int unsigned j = 0; j < r - 1; j++) ov = ov ^ p[j];
    p[r-1] = ov;
    cw = '0;
    for (int unsigned i = 0; i < k; i++) cw[r+i] = info[i];
    for (int unsigned j = 0; j < r; j++) cw[j] = p[j];
    nmask = (n == 32) ? '1 : ((32'd1 << n) - 32'd1);
    return cw ^ (inj & nmask);
  endfunction

  // Scoreboard: transfers are decided at the next posedge, so sample mid-cycle.
  always @(negedge clk) begin
    logic [CW-1:0] inj;
    exp_t          e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'd1, 64'd0);
        end else begin
          check("data_out", 64'(bus.data_out), 64'(exp_q[0].cw));
          check("out_mod", 64'(bus.out_mod), 64'(exp_q[0].mode));
          check("out_err", 64'(bus.out_err), 64'(exp_q[0].err));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
`ifdef ENC_ERR_INJECT_EN
        inj = bus.inj_mask;
`else
        inj = '0;
`endif
        e.cw   = ref_cw(bus.data_in, 32'(bus.work_mod), inj);
        e.mode = bus.work_mod;
        e.err  = (bus.work_mod == 2'd3);
        exp_q.push_back(e);
      end
    end
  end

  task automatic send(input logic [IW-1:0] d, input logic [1:0] m, input bit full_rate);
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.work_mod = m;
    for (int unsigned c = 0; ; c++) begin
      @(negedge clk);
      if (full_rate) check("in_ready_full_rate", 64'(bus.in_ready), 64'd1);
      if (bus.in_ready) break;
      if (c >= 50) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int unsigned c = 0; c < 50 && (exp_q.size() != 0 || bus.out_valid); c++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Word presented before edge t must be on the output after edge t+1.
  task automatic directed(input string tag, input logic [IW-1:0] d, input logic [1:0] m,
                          input logic [CW-1:0] exp_cw, input logic exp_err);
    drain();
    send(d, m, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_data"}, 64'(bus.data_out), 64'(exp_cw));
    check({tag, "_err"}, 64'(bus.out_err), 64'(exp_err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.work_mod  = '0;
    bus.out_ready = 1'b0;
`ifdef ENC_ERR_INJECT_EN
    bus.inj_mask  = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data_out", 64'(bus.data_out), 64'd0);
    check("rst_out_mod", 64'(bus.out_mod), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    directed("m0_1011", 26'b1011, 2'd0, 32'h0000_00B1, 1'b0);
    directed("m1_one", 26'h001, 2'd1, 32'h0000_0033, 1'b0);
    directed("m1_zero", 26'h000, 2'd1, 32'h0000_0000, 1'b0);
    directed("m2_ones", 26'h3FF_FFFF, 2'd2, 32'hFFFF_FFFF, 1'b0);
    directed("m3_illegal", 26'h3FF_FFFF, 2'd3, 32'h0000_0000, 1'b1);
    check("m3_out_mod", 64'(bus.out_mod), 64'd3);
    directed("m0_after_illegal", 26'b1011, 2'd0, 32'h0000_00B1, 1'b0);
    directed("m0_ignore_high", 26'h3FF_FFFB, 2'd0, 32'h0000_00B1, 1'b0);

    drain();
    for (int unsigned i = 0; i < 100; i++)
      send(26'($urandom), 2'($urandom_range(0, 2)), 1'b1);
    drain();

    bus.out_ready = 1'b0;
    send(26'($urandom), 2'd1, 1'b0);
    send(26'($urandom), 2'd2, 1'b0);
    bus.data_in = 26'h155_5555;
    bus.work_mod = 2'd2;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(26'h155_5555, 2'd2, 1'b0);
    drain();

    for (int unsigned i = 0; i < 300; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.data_in   = 26'($urandom);
      bus.work_mod  = 2'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain();

    bus.out_ready = 1'b0;
    send(26'($urandom), 2'd0, 1'b0);
    send(26'($urandom), 2'd2, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

`ifdef ENC_ERR_INJECT_EN
    drain();
    bus.inj_mask = 32'h0000_0101;
    directed("inj_m0", 26'b1011, 2'd0, 32'h0000_00B0, 1'b0);
    directed("inj_illegal", 26'h001, 2'd3, 32'h0000_0000, 1'b1);
    drain();
    bus.inj_mask = '0;
`endif

    drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
